// File: rtl/cpu_8bit.sv
// Single-cycle 8-bit accumulator CPU with internal imem (256x8) and dmem (16x8).
// Define CPU_BRANCH_EN to enable JMP/JZ/JNZ; otherwise those opcodes act as NOP.
module cpu_8bit (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] pc,
   output logic [7:0] acc,
   output logic       halt
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   logic [7:0] imem [0:255];
   logic [7:0] dmem [0:15];

   state_t     state_r;
   state_t     state_next_s;
   logic [7:0] pc_r;
   logic [7:0] acc_r;
   logic [7:0] pc_next_s;
   logic [7:0] acc_next_s;
   logic       dmem_we_s;
   logic [7:0] instr_s;
   logic [3:0] opcode_s;
   logic [3:0] operand_s;
   logic [7:0] mem_data_s;

   assign instr_s    = imem[pc_r];
   assign opcode_s   = instr_s[7:4];
   assign operand_s  = instr_s[3:0];
   assign mem_data_s = dmem[operand_s];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: HLT is the only way out of RUN, reset the only way back
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         RUN: begin
            if (opcode_s == 4'hF) begin
               state_next_s = HALTED;
            end else begin
               state_next_s = RUN;
            end
         end
         HALTED:  state_next_s = HALTED;
         default: state_next_s = RUN;
      endcase
   end

   // Instruction execute: next pc/acc and dmem write enable
   always_comb begin
      pc_next_s  = pc_r;
      acc_next_s = acc_r;
      dmem_we_s  = 1'b0;
      if (state_r == RUN) begin
         pc_next_s = pc_r + 8'd1;
         case (opcode_s)
            4'h1: acc_next_s = mem_data_s;
            4'h2: dmem_we_s  = 1'b1;
            4'h3: acc_next_s = acc_r + mem_data_s;
            4'h4: acc_next_s = acc_r - mem_data_s;
            4'h5: acc_next_s = {4'h0, operand_s};
            4'h6: acc_next_s = acc_r & mem_data_s;
            4'h7: acc_next_s = acc_r | mem_data_s;
            4'h8: acc_next_s = acc_r ^ mem_data_s;
`ifdef CPU_BRANCH_EN
            4'h9: pc_next_s = {4'h0, operand_s};
            4'hA: begin
               if (acc_r == 8'd0) begin
                  pc_next_s = {4'h0, operand_s};
               end else begin
                  pc_next_s = pc_r + 8'd1;
               end
            end
            4'hB: begin
               if (acc_r != 8'd0) begin
                  pc_next_s = {4'h0, operand_s};
               end else begin
                  pc_next_s = pc_r + 8'd1;
               end
            end
`endif
            4'hC: acc_next_s = acc_r + 8'd1;
            4'hD: acc_next_s = acc_r - 8'd1;
            4'hF: pc_next_s  = pc_r;
            default: begin
               pc_next_s  = pc_r + 8'd1;
               acc_next_s = acc_r;
            end
         endcase
      end else begin
         pc_next_s  = pc_r;
         acc_next_s = acc_r;
         dmem_we_s  = 1'b0;
      end
   end

   // Architectural registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r  <= 8'd0;
         acc_r <= 8'd0;
      end else begin
         pc_r  <= pc_next_s;
         acc_r <= acc_next_s;
      end
   end

   // Data memory write; an edge seen while reset is held must not store
   always_ff @(posedge clk) begin
      if (dmem_we_s && !rst) begin
         dmem[operand_s] <= acc_r;
      end
   end

   assign pc   = pc_r;
   assign acc  = acc_r;
   assign halt = (state_r == HALTED);

endmodule

// File: tb/tb_cpu_8bit.sv
// Self-checking bench for cpu_8bit: directed program table, multi-cycle corner
// sequences, and random programs checked against an instruction-level model.
module tb_cpu_8bit;

   logic       clk;
   logic       rst;
   logic [7:0] pc;
   logic [7:0] acc;
   logic       halt;

   int checks   = 0;
   int failures = 0;

   cpu_8bit dut (
      .clk  (clk),
      .rst  (rst),
      .pc   (pc),
      .acc  (acc),
      .halt (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CPU_BRANCH_EN
   localparam bit BRANCH = 1'b1;
`else
   localparam bit BRANCH = 1'b0;
`endif

   typedef struct {
      logic [63:0] prog;      // imem[0..7], first byte in the top bits
      logic [31:0] dinit;     // dmem[0..3], dmem[0] in the low byte
      logic [7:0]  exp_acc;
      logic [7:0]  exp_pc;
      logic [3:0]  d_addr;
      logic [7:0]  d_val;
      int          exp_edges;
   } vec_t;

   vec_t vecs [0:9];

   // reference model state
   logic [7:0] m_imem [0:255];
   logic [7:0] m_dmem [0:15];
   logic [7:0] m_pc;
   logic [7:0] m_acc;
   logic       m_halt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic assert_rst();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_pc", {24'd0, pc}, 32'd0);
      check("rst_acc", {24'd0, acc}, 32'd0);
      check("rst_halt", {31'd0, halt}, 32'd0);
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_halt(input int budget, output int edges);
      edges = 0;
      while (!halt && edges < budget) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic model_step();
      logic [3:0] op;
      logic [3:0] n;
      logic [7:0] nxt;
      if (!m_halt) begin
         op  = m_imem[m_pc][7:4];
         n   = m_imem[m_pc][3:0];
         nxt = m_pc + 8'd1;
         case (op)
            4'h1: m_acc = m_dmem[n];
            4'h2: m_dmem[n] = m_acc;
            4'h3: m_acc = m_acc + m_dmem[n];
            4'h4: m_acc = m_acc - m_dmem[n];
            4'h5: m_acc = {4'h0, n};
            4'h6: m_acc = m_acc & m_dmem[n];
            4'h7: m_acc = m_acc | m_dmem[n];
            4'h8: m_acc = m_acc ^ m_dmem[n];
            4'h9: if (BRANCH) nxt = {4'h0, n};
            4'hA: if (BRANCH && m_acc == 8'd0) nxt = {4'h0, n};
            4'hB: if (BRANCH && m_acc != 8'd0) nxt = {4'h0, n};
            4'hC: m_acc = m_acc + 8'd1;
            4'hD: m_acc = m_acc - 8'd1;
            4'hF: begin
               m_halt = 1'b1;
               nxt    = m_pc;
            end
            default: ;
         endcase
         m_pc = nxt;
      end
   endtask

   initial begin
      vec_t v;
      int   edges;
      logic [7:0] pc_hold;
      logic [7:0] acc_hold;

      rst = 1'b1;
      vecs[0] = '{64'h55_31_22_13_42_24_F0_F0, 32'h0A_00_03_00, 8'h02, 8'd6, 4'd4, 8'h02, 7};
      vecs[1] = '{64'h5F_C0_C0_F0_F0_F0_F0_F0, 32'h00_00_00_00, 8'h11, 8'd3, 4'd0, 8'h00, 4};
      vecs[2] = '{64'h50_D0_F0_F0_F0_F0_F0_F0, 32'h00_00_00_00, 8'hFF, 8'd2, 4'd0, 8'h00, 3};
      vecs[3] = '{64'h53_41_F0_F0_F0_F0_F0_F0, 32'h00_00_05_00, 8'hFE, 8'd2, 4'd1, 8'h05, 3};
      vecs[4] = '{64'h5C_60_F0_F0_F0_F0_F0_F0, 32'h00_00_00_0A, 8'h08, 8'd2, 4'd0, 8'h0A, 3};
      vecs[5] = '{64'h5C_70_F0_F0_F0_F0_F0_F0, 32'h00_00_00_0A, 8'h0E, 8'd2, 4'd0, 8'h0A, 3};
      vecs[6] = '{64'h5C_80_F0_F0_F0_F0_F0_F0, 32'h00_00_00_0A, 8'h06, 8'd2, 4'd0, 8'h0A, 3};
      vecs[7] = '{64'h5A_23_50_13_F0_F0_F0_F0, 32'h00_00_00_00, 8'h0A, 8'd4, 4'd3, 8'h0A, 5};
      vecs[8] = '{64'h51_D0_A4_90_F0_F0_F0_F0, 32'h00_00_00_00, 8'h00, 8'd4, 4'd0, 8'h00,
                  BRANCH ? 4 : 5};
      vecs[9] = '{64'h53_E7_C0_F0_F0_F0_F0_F0, 32'h00_00_00_00, 8'h04, 8'd3, 4'd0, 8'h00, 4};

      repeat (2) @(negedge clk);

      // directed program table
      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         assert_rst();
         for (int j = 0; j < 256; j++) dut.imem[j] = 8'hF0;
         for (int j = 0; j < 8; j++) dut.imem[j] = v.prog[63-8*j -: 8];
         for (int j = 0; j < 16; j++) dut.dmem[j] = 8'h00;
         for (int j = 0; j < 4; j++) dut.dmem[j] = v.dinit[8*j +: 8];
         release_rst();
         wait_halt(20, edges);
         check($sformatf("v%0d_halt", i), {31'd0, halt}, 32'd1);
         check($sformatf("v%0d_edges", i), edges, v.exp_edges);
         check($sformatf("v%0d_acc", i), {24'd0, acc}, {24'd0, v.exp_acc});
         check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, v.exp_pc});
         check($sformatf("v%0d_dmem", i), {24'd0, dut.dmem[v.d_addr]}, {24'd0, v.d_val});
         repeat (2) @(negedge clk);
         check($sformatf("v%0d_frozen_pc", i), {24'd0, pc}, {24'd0, v.exp_pc});
         check($sformatf("v%0d_frozen_acc", i), {24'd0, acc}, {24'd0, v.exp_acc});
         check($sformatf("v%0d_frozen_halt", i), {31'd0, halt}, 32'd1);
      end

      // asynchronous reset in the middle of a run
      assert_rst();
      for (int j = 0; j < 256; j++) dut.imem[j] = 8'hF0;
      dut.imem[0] = 8'h57;
      dut.imem[1] = 8'h20;
      for (int j = 2; j < 10; j++) dut.imem[j] = 8'hC0;
      dut.imem[10] = 8'h21;
      for (int j = 0; j < 16; j++) dut.dmem[j] = 8'h00;
      release_rst();
      repeat (5) @(negedge clk);
      check("mid_pc_before", {24'd0, pc}, 32'd5);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_pc", {24'd0, pc}, 32'd0);
      check("mid_rst_acc", {24'd0, acc}, 32'd0);
      check("mid_rst_halt", {31'd0, halt}, 32'd0);
      repeat (2) @(negedge clk);
      check("mid_rst_hold_pc", {24'd0, pc}, 32'd0);
      check("mid_dmem0_kept", {24'd0, dut.dmem[0]}, 32'h07);
      check("mid_dmem1_clean", {24'd0, dut.dmem[1]}, 32'h00);
      rst = 1'b0;
      wait_halt(30, edges);
      check("mid_rerun_edges", edges, 12);
      check("mid_rerun_acc", {24'd0, acc}, 32'h0F);
      check("mid_rerun_pc", {24'd0, pc}, 32'd11);
      check("mid_rerun_dmem1", {24'd0, dut.dmem[1]}, 32'h0F);

      // pc wraps 255 -> 0
      assert_rst();
      for (int j = 0; j < 256; j++) dut.imem[j] = 8'h00;
      release_rst();
      edges = 0;
      while (pc != 8'd253 && edges < 300) begin
         @(negedge clk);
         edges++;
      end
      check("wrap_reach_253", {24'd0, pc}, 32'd253);
      dut.imem[0] = 8'hF0;
      @(negedge clk);
      check("wrap_pc_254", {24'd0, pc}, 32'd254);
      @(negedge clk);
      check("wrap_pc_255", {24'd0, pc}, 32'd255);
      @(negedge clk);
      check("wrap_pc_0", {24'd0, pc}, 32'd0);
      check("wrap_not_halted", {31'd0, halt}, 32'd0);
      @(negedge clk);
      check("wrap_halt", {31'd0, halt}, 32'd1);
      check("wrap_halt_pc", {24'd0, pc}, 32'd0);

      // random programs against the instruction-level model
      for (int r = 0; r < 20; r++) begin
         assert_rst();
         for (int j = 0; j < 256; j++) begin
            m_imem[j]   = 8'($urandom_range(0, 255));
            dut.imem[j] = m_imem[j];
         end
         for (int j = 0; j < 16; j++) begin
            m_dmem[j]   = 8'($urandom_range(0, 255));
            dut.dmem[j] = m_dmem[j];
         end
         m_pc   = 8'd0;
         m_acc  = 8'd0;
         m_halt = 1'b0;
         release_rst();
         for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            model_step();
            check($sformatf("rnd%0d_pc", r), {24'd0, pc}, {24'd0, m_pc});
            check($sformatf("rnd%0d_acc", r), {24'd0, acc}, {24'd0, m_acc});
            check($sformatf("rnd%0d_halt", r), {31'd0, halt}, {31'd0, m_halt});
         end
         for (int j = 0; j < 16; j++) begin
            check($sformatf("rnd%0d_dmem%0d", r, j), {24'd0, dut.dmem[j]}, {24'd0, m_dmem[j]});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_8bit.md
# cpu_8bit

Minimal 8-bit accumulator processor with internal instruction and data memories, executing one instruction per clock. It is the top-level compute block of the mc_8bit design. The program counter, accumulator and halt status are exported for observation. Benches load the program by writing the internal memory arrays hierarchically before releasing reset.

## Interface
- No parameters. Memory sizes are fixed: imem 256 x 8, dmem 16 x 8.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous active-high reset
- pc  output  8  current program counter (address of the instruction being executed)
- acc  output  8  accumulator register
- halt  output  1  high once HLT has executed; sticky until reset

## Operation
- Internal arrays must be named exactly `imem` [0:255] and `dmem` [0:15], each 8 bits wide, declared at the module top level so they are hierarchically writable.
- Reset does not clear either memory.
- Both memories are read asynchronously. dmem is written synchronously.
- Instruction format: opcode = instr[7:4], operand n = instr[3:0]. For memory ops, n is the dmem address.
- Opcodes:
  - 0 NOP
  - 1 LDA: acc = dmem[n]
  - 2 STA: dmem[n] = acc
  - 3 ADD: acc = acc + dmem[n]
  - 4 SUB: acc = acc - dmem[n]
  - 5 LDI: acc = {4'h0, n}
  - 6 AND: acc = acc & dmem[n]
  - 7 OR: acc = acc | dmem[n]
  - 8 XOR: acc = acc ^ dmem[n]
  - 9 JMP: pc = {4'h0, n}
  - A JZ: jump to {4'h0, n} if acc == 0
  - B JNZ: jump to {4'h0, n} if acc != 0
  - C INC: acc = acc + 1
  - D DEC: acc = acc - 1
  - E: reserved, executes as NOP
  - F HLT
- Arithmetic is modulo 256. There are no carry or overflow flags.
- Non-jump instructions advance pc by 1. pc wraps from 255 to 0.
- HLT:
  - sets halt to 1
  - leaves pc at the HLT address
  - leaves acc and memories unchanged
- While halt is 1, no instruction executes: pc, acc and dmem are frozen.
- Two states: RUN and HALTED. RUN goes to HALTED on HLT. HALTED goes to RUN only on rst.

## Timing
- Single-cycle execution. At each rising edge in RUN, the instruction at imem[pc] commits: acc, pc and any dmem write update together.
- Reset values: pc = 0, acc = 0, halt = 0. These apply immediately on rst assertion, independent of clk.
- Reset mid-program: aborts the current instruction with no dmem write. Execution restarts at address 0 on the first rising edge after rst deasserts.
- STA followed by LDA of the same address: the LDA sees the newly stored value, because the write commits one edge earlier.
- halt rises at the same edge that executes HLT.
- An N-instruction straight-line program ending in HLT asserts halt N edges after reset release.

## Configuration
- `CPU_BRANCH_EN` defined: opcodes 9, A and B perform the jumps defined above.
- `CPU_BRANCH_EN` undefined: opcodes 9, A and B execute as NOP (pc + 1) and no branch logic is synthesized.
- All other behaviour is identical in both builds.

## Test plan
- Default program. Load imem[0..6] = 55 31 22 13 42 24 F0, dmem[1] = 03, dmem[3] = 0A; pulse rst. Required: dmem[2] = 8, dmem[4] = 2, acc = 2, pc = 6, halt = 1 within 7 edges of rst release; state stays frozen for 2 further cycles.
- Wrap-around. Program 5F C0 C0 F0 with dmem cleared. Required: acc = 0x11. Separately, LDI 0 then DEC gives acc = 0xFF, and SUB of a larger value wraps modulo 256.
- Logic ops. acc = 0x0C with dmem[0] = 0x0A. Required: AND gives 0x08, OR gives 0x0E, XOR gives 0x06.
- Branching with `CPU_BRANCH_EN`. Program 51 D0 A4 90 F0 (LDI 1, DEC, JZ 4, JMP 0, HLT). Required: halt at pc = 4 with acc = 0. Without the macro, the same program halts at pc = 4 after running straight through.
- Reset mid-run. Assert rst asynchronously (not aligned to clk) mid-program. Required: pc, acc and halt read 0 immediately; dmem contents are preserved; the program reruns to the same results.
- PC wrap. imem filled with NOP and imem[0] = F0, started from reset after the first pass. Required: pc sequence ...254, 255, 0 and halt at 0; a NOP at imem[255] wraps pc to 0.
